// File: rtl/operand_forward_unit_pkg.sv
// -----------------------------------------------------------------------------
// operand_forward_unit_pkg
// Shared definitions for the operand-forwarding scoreboard:
//   - default widths and depth of the forwarding block
//   - index constants of the EX and MEM stages in the in-flight entry array
//   - fwd_entry_t: one in-flight register write (v, rd, dv, data) at the
//     default widths. The top module re-declares the same layout so that the
//     field widths follow its own parameters.
// -----------------------------------------------------------------------------
package operand_forward_unit_pkg;

   localparam int DEF_DATA_W  = 16;
   localparam int DEF_RADDR_W = 3;
   localparam int DEF_STAGES  = 3;
   localparam int DEF_NUM_SRC = 2;

   localparam int EX_IDX  = 0;
   localparam int MEM_IDX = 1;

   typedef struct packed {
      logic                   v;     // entry holds a register write
      logic [DEF_RADDR_W-1:0] rd;    // destination register
      logic                   dv;    // result data is available
      logic [DEF_DATA_W-1:0]  data;  // result data
   } fwd_entry_t;

endpackage

// File: rtl/fwd_port_resolve.sv
// -----------------------------------------------------------------------------
// fwd_port_resolve
// Priority search of the in-flight write list for one source read port.
// Slot 0 is the youngest write; the first slot with v && rd == i_addr wins.
// Ports:
//   i_addr     source register address
//   i_rf_data  register-file read data for this port
//   i_v, i_dv  per-slot valid / data-valid flags
//   i_rd       per-slot destination, slot j at [j*RADDR_W +: RADDR_W]
//   i_data     per-slot result, slot j at [j*DATA_W +: DATA_W]
//   o_data     resolved operand
//   o_hit      youngest match carries data and was forwarded
//   o_hazard   youngest match has no data yet
// -----------------------------------------------------------------------------
module fwd_port_resolve #(
   parameter int DATA_W  = 16,
   parameter int RADDR_W = 3,
   parameter int DEPTH   = 3
) (
   input  logic [RADDR_W-1:0]       i_addr,
   input  logic [DATA_W-1:0]        i_rf_data,
   input  logic [DEPTH-1:0]         i_v,
   input  logic [DEPTH-1:0]         i_dv,
   input  logic [DEPTH*RADDR_W-1:0] i_rd,
   input  logic [DEPTH*DATA_W-1:0]  i_data,
   output logic [DATA_W-1:0]        o_data,
   output logic                     o_hit,
   output logic                     o_hazard
);

   logic              w_found;
   logic              w_found_dv;
   logic [DATA_W-1:0] w_found_data;

   // Walk from the oldest slot to the youngest so a younger match always
   // overwrites an older one.
   always_comb begin
      w_found      = 1'b0;
      w_found_dv   = 1'b0;
      w_found_data = '0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (i_v[i] && (i_rd[i*RADDR_W +: RADDR_W] == i_addr)) begin
            w_found      = 1'b1;
            w_found_dv   = i_dv[i];
            w_found_data = i_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign o_hit    = w_found &&  w_found_dv;
   assign o_hazard = w_found && !w_found_dv;
   assign o_data   = o_hit ? w_found_data : i_rf_data;

endmodule

// File: rtl/operand_forward_unit.sv
// -----------------------------------------------------------------------------
// operand_forward_unit
// Operand forwarding and load-use hazard detection between register read and
// the operand buffer. A scoreboard of STAGES in-flight register writes
// (entry 0 = EX, 1 = MEM, last = WB) is searched per source port; the
// youngest matching write supplies the operand, or raises a stall when its
// result is not produced yet.
// Optional feature (macro WB_BYPASS_EN): the entry that retired last cycle
// is kept for one more cycle and searched at lowest priority, for register
// files without write-before-read.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   hold_i          pipeline hold, entries do not shift (fills still apply)
//   flush_i         invalidate all in-flight entries
//   issue_we_i/rd_i write enable / destination of the issuing instruction
//   ex_valid_i/data EX result for entry 0
//   mem_valid_i/data late (load) result for entry 1
//   src_addr_i      per-port source addresses
//   rf_data_i       per-port register-file read data
//   src_data_o      per-port resolved operands
//   fwd_hit_o       per-port forwarded flag
//   stall_o         load-use hazard, stage 2 must hold
// -----------------------------------------------------------------------------
module operand_forward_unit
   import operand_forward_unit_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int RADDR_W = DEF_RADDR_W,
   parameter int STAGES  = DEF_STAGES,
   parameter int NUM_SRC = DEF_NUM_SRC
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       hold_i,
   input  logic                       flush_i,
   input  logic                       issue_we_i,
   input  logic [RADDR_W-1:0]         issue_rd_i,
   input  logic                       ex_valid_i,
   input  logic [DATA_W-1:0]          ex_data_i,
   input  logic                       mem_valid_i,
   input  logic [DATA_W-1:0]          mem_data_i,
   input  logic [NUM_SRC*RADDR_W-1:0] src_addr_i,
   input  logic [NUM_SRC*DATA_W-1:0]  rf_data_i,
   output logic [NUM_SRC*DATA_W-1:0]  src_data_o,
   output logic [NUM_SRC-1:0]         fwd_hit_o,
   output logic                       stall_o
);

   // Same layout as fwd_entry_t, sized by this instance's parameters.
   typedef struct packed {
      logic               v;
      logic [RADDR_W-1:0] rd;
      logic               dv;
      logic [DATA_W-1:0]  data;
   } entry_t;

`ifdef WB_BYPASS_EN
   localparam int DEPTH = STAGES + 1;
`else
   localparam int DEPTH = STAGES;
`endif

   entry_t r_ent [STAGES];
`ifdef WB_BYPASS_EN
   entry_t r_ret;
`endif
   entry_t w_eff [STAGES];

   logic [DEPTH-1:0]          w_v;
   logic [DEPTH-1:0]          w_dv;
   logic [DEPTH*RADDR_W-1:0]  w_rd;
   logic [DEPTH*DATA_W-1:0]   w_dat;
   logic [NUM_SRC-1:0]        w_hit;
   logic [NUM_SRC-1:0]        w_hazard;
   logic [NUM_SRC*DATA_W-1:0] w_data;
   logic                      w_stall;

   // Live view: results arriving this cycle are visible to the search in
   // the same cycle. A late result never overwrites data already held.
   always_comb begin
      for (int i = 0; i < STAGES; i++) begin
         w_eff[i] = r_ent[i];
      end
      if (ex_valid_i) begin
         w_eff[EX_IDX].dv   = 1'b1;
         w_eff[EX_IDX].data = ex_data_i;
      end
      if (mem_valid_i && !r_ent[MEM_IDX].dv) begin
         w_eff[MEM_IDX].dv   = 1'b1;
         w_eff[MEM_IDX].data = mem_data_i;
      end
   end

   // Flatten the search list, youngest first; the retired slot goes last.
   always_comb begin
      w_v   = '0;
      w_dv  = '0;
      w_rd  = '0;
      w_dat = '0;
      for (int i = 0; i < STAGES; i++) begin
         w_v[i]                     = w_eff[i].v;
         w_dv[i]                    = w_eff[i].dv;
         w_rd[i*RADDR_W +: RADDR_W] = w_eff[i].rd;
         w_dat[i*DATA_W +: DATA_W]  = w_eff[i].data;
      end
`ifdef WB_BYPASS_EN
      w_v[STAGES]                     = r_ret.v;
      w_dv[STAGES]                    = r_ret.dv;
      w_rd[STAGES*RADDR_W +: RADDR_W] = r_ret.rd;
      w_dat[STAGES*DATA_W +: DATA_W]  = r_ret.data;
`endif
   end

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_port
      fwd_port_resolve #(
         .DATA_W  (DATA_W),
         .RADDR_W (RADDR_W),
         .DEPTH   (DEPTH)
      ) u_resolve (
         .i_addr    (src_addr_i[k*RADDR_W +: RADDR_W]),
         .i_rf_data (rf_data_i[k*DATA_W +: DATA_W]),
         .i_v       (w_v),
         .i_dv      (w_dv),
         .i_rd      (w_rd),
         .i_data    (w_dat),
         .o_data    (w_data[k*DATA_W +: DATA_W]),
         .o_hit     (w_hit[k]),
         .o_hazard  (w_hazard[k])
      );
   end

   assign w_stall = |w_hazard;

   // Entry contents are stale while reset is applied, so outputs fall back
   // to the register file.
   assign stall_o    = rst ? 1'b0      : w_stall;
   assign fwd_hit_o  = rst ? '0        : w_hit;
   assign src_data_o = rst ? rf_data_i : w_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            r_ent[i] <= '0;
         end
`ifdef WB_BYPASS_EN
         r_ret <= '0;
`endif
      end else if (flush_i) begin
         for (int i = 0; i < STAGES; i++) begin
            r_ent[i].v <= 1'b0;
         end
`ifdef WB_BYPASS_EN
         r_ret.v <= 1'b0;
`endif
      end else if (hold_i) begin
         // Frozen in place, but arriving results are still captured.
         for (int i = 0; i < STAGES; i++) begin
            r_ent[i] <= w_eff[i];
         end
      end else begin
         // A stalled issue enters as a bubble.
         r_ent[EX_IDX] <= '{v: issue_we_i && !w_stall, rd: issue_rd_i,
                            dv: 1'b0, data: '0};
         for (int i = 1; i < STAGES; i++) begin
            r_ent[i] <= w_eff[i-1];
         end
`ifdef WB_BYPASS_EN
         r_ret <= w_eff[STAGES-1];
`endif
      end
   end

endmodule

// File: tb/tb_operand_forward_unit.sv
// -----------------------------------------------------------------------------
// tb_operand_forward_unit
// Directed stimulus with a behavioural scoreboard model of the in-flight
// writes, a per-cycle compare process and hand-computed literal checks.
// Honours WB_BYPASS_EN for the retired-write slot.
// -----------------------------------------------------------------------------
module tb_operand_forward_unit;
   import operand_forward_unit_pkg::*;

   localparam int DW = DEF_DATA_W;
   localparam int AW = DEF_RADDR_W;
   localparam int ST = DEF_STAGES;
   localparam int NS = DEF_NUM_SRC;

   logic             clk;
   logic             rst;
   logic             hold_i;
   logic             flush_i;
   logic             issue_we_i;
   logic [AW-1:0]    issue_rd_i;
   logic             ex_valid_i;
   logic [DW-1:0]    ex_data_i;
   logic             mem_valid_i;
   logic [DW-1:0]    mem_data_i;
   logic [NS*AW-1:0] src_addr_i;
   logic [NS*DW-1:0] rf_data_i;
   logic [NS*DW-1:0] src_data_o;
   logic [NS-1:0]    fwd_hit_o;
   logic             stall_o;

   operand_forward_unit #(
      .DATA_W (DW), .RADDR_W (AW), .STAGES (ST), .NUM_SRC (NS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .hold_i      (hold_i),
      .flush_i     (flush_i),
      .issue_we_i  (issue_we_i),
      .issue_rd_i  (issue_rd_i),
      .ex_valid_i  (ex_valid_i),
      .ex_data_i   (ex_data_i),
      .mem_valid_i (mem_valid_i),
      .mem_data_i  (mem_data_i),
      .src_addr_i  (src_addr_i),
      .rf_data_i   (rf_data_i),
      .src_data_o  (src_data_o),
      .fwd_hit_o   (fwd_hit_o),
      .stall_o     (stall_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_ent[0] is the youngest in-flight write.
   fwd_entry_t m_ent [ST];
`ifdef WB_BYPASS_EN
   fwd_entry_t m_ret;
`endif

   // Entry as seen this cycle, with results arriving now applied.
   function automatic fwd_entry_t live(input int i);
      fwd_entry_t e;
      e = m_ent[i];
      if (i == 0 && ex_valid_i) begin
         e.dv   = 1'b1;
         e.data = ex_data_i;
      end
      if (i == 1 && mem_valid_i && !m_ent[1].dv) begin
         e.dv   = 1'b1;
         e.data = mem_data_i;
      end
      return e;
   endfunction

   // Expected outputs for port k: youngest write to the register wins.
   function automatic void expect_port(input int k, output logic [DW-1:0] d,
                                       output logic hit, output logic haz);
      logic [AW-1:0] a;
      fwd_entry_t    e;
      a   = src_addr_i[k*AW +: AW];
      d   = rf_data_i[k*DW +: DW];
      hit = 1'b0;
      haz = 1'b0;
      if (rst) return;
      for (int i = 0; i < ST; i++) begin
         e = live(i);
         if (e.v && e.rd == a) begin
            if (e.dv) begin
               d   = e.data;
               hit = 1'b1;
            end else begin
               haz = 1'b1;
            end
            return;
         end
      end
`ifdef WB_BYPASS_EN
      if (m_ret.v && m_ret.rd == a) begin
         if (m_ret.dv) begin
            d   = m_ret.data;
            hit = 1'b1;
         end else begin
            haz = 1'b1;
         end
      end
`endif
   endfunction

   function automatic logic model_stall();
      logic [DW-1:0] d;
      logic          h;
      logic          z;
      logic          s;
      s = 1'b0;
      for (int k = 0; k < NS; k++) begin
         expect_port(k, d, h, z);
         s = s | z;
      end
      return s;
   endfunction

   // Model state update on each rising edge.
   initial begin
      fwd_entry_t nxt [ST];
      logic       st;
      for (int i = 0; i < ST; i++) m_ent[i] = '0;
`ifdef WB_BYPASS_EN
      m_ret = '0;
`endif
      forever begin
         @(posedge clk);
         if (rst) begin
            for (int i = 0; i < ST; i++) m_ent[i] = '0;
`ifdef WB_BYPASS_EN
            m_ret = '0;
`endif
         end else if (flush_i) begin
            for (int i = 0; i < ST; i++) m_ent[i].v = 1'b0;
`ifdef WB_BYPASS_EN
            m_ret.v = 1'b0;
`endif
         end else begin
            st = model_stall();
            for (int i = 0; i < ST; i++) nxt[i] = live(i);
            if (hold_i) begin
               for (int i = 0; i < ST; i++) m_ent[i] = nxt[i];
            end else begin
`ifdef WB_BYPASS_EN
               m_ret = nxt[ST-1];
`endif
               for (int i = ST-1; i >= 1; i--) m_ent[i] = nxt[i-1];
               m_ent[0].v    = issue_we_i && !st;
               m_ent[0].rd   = issue_rd_i;
               m_ent[0].dv   = 1'b0;
               m_ent[0].data = '0;
            end
         end
      end
   end

   // Compare process: every falling edge once checking is enabled.
   initial begin
      logic [DW-1:0] d;
      logic          h;
      logic          z;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            for (int k = 0; k < NS; k++) begin
               expect_port(k, d, h, z);
               check($sformatf("model src%0d_data", k), 32'(src_data_o[k*DW +: DW]), 32'(d));
               check($sformatf("model fwd_hit%0d", k), 32'(fwd_hit_o[k]), 32'(h));
            end
            check("model stall", 32'(stall_o), 32'(model_stall()));
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
      rst         = 1'b0;
      hold_i      = 1'b0;
      flush_i     = 1'b0;
      issue_we_i  = 1'b0;
      issue_rd_i  = '0;
      ex_valid_i  = 1'b0;
      ex_data_i   = '0;
      mem_valid_i = 1'b0;
      mem_data_i  = '0;
      src_addr_i  = '0;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic src(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      src_addr_i = {a1, a0};
   endtask

   task automatic issue(input logic [AW-1:0] rd);
      issue_we_i = 1'b1;
      issue_rd_i = rd;
   endtask

   initial begin
      rst = 1'b1; hold_i = 0; flush_i = 0; issue_we_i = 0; issue_rd_i = '0;
      ex_valid_i = 0; ex_data_i = '0; mem_valid_i = 0; mem_data_i = '0;
      src_addr_i = '0;
      rf_data_i  = {16'hAAAA, 16'h5555};

      // Reset: outputs fall back to the register file.
      cyc(); rst = 1'b1; src(3'd1, 3'd2); settle();
      chk_en = 1'b1;
      check("rst stall", 32'(stall_o), 32'h0);
      check("rst hit", 32'(fwd_hit_o), 32'h0);
      check("rst src", 32'(src_data_o), 32'hAAAA5555);
      cyc();

      // Back-to-back ALU dependency on R3.
      cyc(); issue(3'd3);
      cyc(); ex_valid_i = 1; ex_data_i = 16'h1234; src(3'd3, 3'd0); settle();
      check("b2b src0", 32'(src_data_o[15:0]), 32'h1234);
      check("b2b hit", 32'(fwd_hit_o), 32'h1);
      check("b2b stall", 32'(stall_o), 32'h0);
      cyc(); src(3'd3, 3'd0); settle();
      check("b2b mem src0", 32'(src_data_o[15:0]), 32'h1234);

      // Load-use on R2; the stalled R6 issue becomes a bubble.
      cyc(); issue(3'd2);
      cyc(); src(3'd0, 3'd2); issue(3'd6); settle();
      check("ld stall", 32'(stall_o), 32'h1);
      check("ld hit", 32'(fwd_hit_o), 32'h0);
      check("ld src1 rf", 32'(src_data_o[31:16]), 32'hAAAA);
      cyc(); mem_valid_i = 1; mem_data_i = 16'hBEEF; src(3'd6, 3'd2); settle();
      check("ld fill src1", 32'(src_data_o[31:16]), 32'hBEEF);
      check("ld fill stall", 32'(stall_o), 32'h0);
      check("ld fill hit", 32'(fwd_hit_o), 32'h2);

      // Youngest wins: R1 twice in flight.
      cyc(); issue(3'd1);
      cyc(); ex_valid_i = 1; ex_data_i = 16'h0001; issue(3'd7);
      cyc(); ex_valid_i = 1; ex_data_i = 16'h0777; issue(3'd1);
      cyc(); ex_valid_i = 1; ex_data_i = 16'h0002; src(3'd1, 3'd0); issue(3'd1); settle();
      check("young src0", 32'(src_data_o[15:0]), 32'h0002);
      check("young hit", 32'(fwd_hit_o), 32'h1);
      // Youngest R1 has no data: stall although an older R1 has data.
      cyc(); src(3'd1, 3'd0); settle();
      check("young haz stall", 32'(stall_o), 32'h1);
      check("young haz src0", 32'(src_data_o[15:0]), 32'h5555);
      cyc(); mem_valid_i = 1; mem_data_i = 16'h0003; src(3'd1, 3'd0); settle();
      check("young fill src0", 32'(src_data_o[15:0]), 32'h0003);
      check("young fill stall", 32'(stall_o), 32'h0);

      // No match.
      cyc(); src(3'd5, 3'd5); settle();
      check("nomatch src", 32'(src_data_o), 32'hAAAA5555);
      check("nomatch hit", 32'(fwd_hit_o), 32'h0);

      // Flush with three pending writes.
      cyc(); issue(3'd4);
      cyc(); issue(3'd5);
      cyc(); issue(3'd6);
      cyc(); flush_i = 1;
      cyc(); src(3'd4, 3'd6); settle();
      check("flush src", 32'(src_data_o), 32'hAAAA5555);
      check("flush stall", 32'(stall_o), 32'h0);
      check("flush hit", 32'(fwd_hit_o), 32'h0);

      // Reset during a stall.
      cyc(); issue(3'd2);
      cyc(); src(3'd2, 3'd0); settle();
      check("rststall pre", 32'(stall_o), 32'h1);
      cyc(); rst = 1'b1; src(3'd2, 3'd0); settle();
      check("rststall during", 32'(stall_o), 32'h0);
      cyc(); src(3'd2, 3'd0); settle();
      check("rststall after", 32'(stall_o), 32'h0);
      check("rststall hit", 32'(fwd_hit_o), 32'h0);

      // Hold for two cycles; load result arrives during the hold.
      cyc(); issue(3'd2);
      cyc(); src(3'd0, 3'd2); settle();
      check("hold pre stall", 32'(stall_o), 32'h1);
      cyc(); hold_i = 1; src(3'd0, 3'd2); settle();
      check("hold1 stall", 32'(stall_o), 32'h1);
      cyc(); hold_i = 1; mem_valid_i = 1; mem_data_i = 16'hCAFE; src(3'd0, 3'd2); issue(3'd3); settle();
      check("hold2 src1", 32'(src_data_o[31:16]), 32'hCAFE);
      check("hold2 stall", 32'(stall_o), 32'h0);
      check("hold2 hit", 32'(fwd_hit_o), 32'h2);
      cyc(); src(3'd3, 3'd2); settle();
      check("post hold src1", 32'(src_data_o[31:16]), 32'hCAFE);
      check("post hold hit", 32'(fwd_hit_o), 32'h2);
      cyc(); src(3'd0, 3'd2); settle();
      check("wb src1", 32'(src_data_o[31:16]), 32'hCAFE);
      cyc(); src(3'd0, 3'd2); settle();
`ifdef WB_BYPASS_EN
      check("retired src1", 32'(src_data_o[31:16]), 32'hCAFE);
      check("retired hit", 32'(fwd_hit_o), 32'h2);
`else
      check("retired src1", 32'(src_data_o[31:16]), 32'hAAAA);
      check("retired hit", 32'(fwd_hit_o), 32'h0);
`endif

      cyc();
      cyc();
      @(posedge clk);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/operand_forward_unit.md
Name: operand_forward_unit

Overview:
Parametrised operand-forwarding and hazard block for the pipelined core. It generalises the single-operand, flag-driven forward mux into a tracked scoreboard of in-flight register writes. Each source read port takes the youngest matching in-flight value, or the register-file value when nothing matches. When the youngest producer has no data yet, the block raises a stall. It sits between register read (stage 2) and the operand buffer feeding execute.

Parameters:
DATA_W, 16, operand/result width in bits
RADDR_W, 3, register address width (2**RADDR_W registers)
STAGES, 3, tracked in-flight stages after issue: entry 0 = EX, 1 = MEM, last = WB
NUM_SRC, 2, number of source operand read ports

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
hold_i  in  1  pipeline hold; entries do not shift
flush_i  in  1  invalidate all in-flight entries
issue_we_i  in  1  instruction leaving stage 2 writes a register
issue_rd_i  in  RADDR_W  destination of that instruction
ex_valid_i  in  1  EX result available this cycle (entry 0)
ex_data_i  in  DATA_W  EX result
mem_valid_i  in  1  late (load) result available this cycle (entry 1)
mem_data_i  in  DATA_W  late result
src_addr_i  in  NUM_SRC*RADDR_W  source register addresses, port k at [k*RADDR_W +: RADDR_W]
rf_data_i  in  NUM_SRC*DATA_W  register-file read data per port
src_data_o  out  NUM_SRC*DATA_W  resolved operands to the operand buffer
fwd_hit_o  out  NUM_SRC  port k was forwarded, not taken from the register file
stall_o  out  1  load-use hazard; stage 2 must hold

Behaviour:
- Entry fields: v, rd, dv (data valid), data. Reset: all v = 0, dv = 0, data = 0.
- Outputs are combinational from the entries. Under reset: stall_o = 0, fwd_hit_o = 0, src_data_o = rf_data_i.
- Shift on a rising clk when !hold_i && !rst:
  - entry[i+1] <= entry[i]; the last entry retires and is dropped.
  - entry[0] <= {issue_we_i && !stall_o, issue_rd_i, 0, 0}.
- Fill before shift:
  - If ex_valid_i, entry[0] takes dv = 1 and data = ex_data_i; shift then carries it on.
  - If mem_valid_i and entry[1] has dv = 0, entry[1] takes mem_data_i, dv = 1.
  - Fills apply even while hold_i is high; the entry stays in place.
- Live view: effective entry[0] = registered entry[0] with ex_valid_i/ex_data_i overlaid; entry[1] likewise with mem_valid_i/mem_data_i.
- Port resolve: search effective entries 0..STAGES-1 and take the first (youngest) with v && rd == src_addr.
  - Match with dv = 1: src_data_o = its data, fwd_hit_o = 1.
  - Match with dv = 0: port hazard; src_data_o = rf_data_i.
  - No match: src_data_o = rf_data_i, fwd_hit_o = 0.
- stall_o = OR of port hazards. While stall_o is high, a bubble (v = 0) is inserted into entry 0.
- flush_i takes priority over shift and fill: all v = 0 next cycle. hold_i is ignored during flush.
- rst takes priority over everything. Reset during a stall clears it on the next cycle.
- The same register in several entries is resolved by youngest-wins; an older match is never used.

Optional Feature:
Macro: WB_BYPASS_EN.
- Defined: the search also covers a retired-write slot, i.e. the entry dropped last cycle, held for one cycle. This covers register files without write-before-read; priority is lowest, below entry STAGES-1.
- Undefined: retired entries are dropped immediately, and the register file must write-through.

Decomposition:
- Shared package: the entry struct typedef (v, rd, dv, data), the stage-index constants (EX_IDX = 0, MEM_IDX = 1), and the default widths.
- Sub-module: fwd_port_resolve, a per-port priority search, instantiated NUM_SRC times in a generate loop. The scoreboard stays in the top module.

Test Plan:
- Back-to-back ALU dependency: issue R3 with ex_data = 0x1234, next cycle src0 = R3 -> src_data_o[0] = 0x1234, fwd_hit_o = 01, stall_o = 0.
- Load-use: issue R2 with ex_valid = 0, next cycle src1 = R2 -> stall_o = 1 for one cycle. Then mem_valid with 0xBEEF -> src_data_o[1] = 0xBEEF, stall_o = 0.
- Youngest wins: R1 = 0x0001 in entry 2 and R1 = 0x0002 in entry 0, read R1 -> 0x0002.
- No match: read R5 with rf_data = 0x5555 -> output 0x5555, fwd_hit_o = 0.
- Flush with 3 pending entries, read any pending register -> rf_data_i, stall_o = 0. Reset asserted mid-stall -> stall_o = 0 the next cycle.
- Hold for 2 cycles: entries frozen; mem_valid during the hold fills entry 1 and the stall clears without a shift. With WB_BYPASS_EN, a read one cycle after retirement returns the retired data.
